// File: rtl/counter_mod_updown_cascade.sv
// Up/down modulo counter with a run-time programmable modulus, a cascade carry,
// synchronous clear/load and optional one-shot halt at the terminal count.
module counter_mod_updown_cascade #(
    parameter int WIDTH       = 8,
    parameter int MOD_DEFAULT = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_ena,
    input  logic             cnt_ena,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] dfload,
    input  logic             mod_load,
    input  logic [WIDTH-1:0] mod_val,
    input  logic             dir,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] mod_q,
    output logic             carry,
    output logic             tc_r,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MOD_RST = WIDTH'(MOD_DEFAULT);

    logic             tc;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] mod_next;
    logic             tc_next;
    logic             done_next;

    assign tc    = dir ? (q == '0) : (q == mod_q - ONE);
    assign carry = clk_ena & cnt_ena & tc & ~done;

    always_comb begin
        q_next    = q;
        mod_next  = mod_q;
        tc_next   = 1'b0;
        done_next = done;

        if (srst) begin
            q_next    = '0;
            done_next = 1'b0;
        end else if (load) begin
            done_next = 1'b0;
            q_next    = (dfload >= mod_q) ? mod_q - ONE : dfload;
        end else if (cnt_ena && !done) begin
            if (tc) begin
                tc_next = 1'b1;
                if (one_shot) begin
                    done_next = 1'b1;
                end else begin
                    q_next = dir ? mod_q - ONE : '0;
                end
            end else begin
                q_next = dir ? q - ONE : q + ONE;
            end
        end

        // The step above used the old modulus; pull q back into range of the new one.
        if (mod_load && (mod_val != '0)) begin
            mod_next = mod_val;
            if (q_next >= mod_val) begin
                q_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            mod_q <= MOD_RST;
            tc_r  <= 1'b0;
            done  <= 1'b0;
        end else if (clk_ena) begin
            q     <= q_next;
            mod_q <= mod_next;
            tc_r  <= tc_next;
            done  <= done_next;
        end
    end

endmodule

// File: doc/counter_mod_updown_cascade.md
Name: counter_mod_updown_cascade

Overview:
- Parametrised up/down modulo counter. Supersedes the fixed-modulus load counters.
- Modulus is programmable at run time; features:
  - direction select
  - synchronous clear and load
  - cascade carry-in/carry-out
  - free-run or one-shot mode
- Used as a general address, timer and divider counter. Instances chain through cnt_ena/carry to build wider or multi-stage dividers.

Parameters:
- WIDTH, 8, width of count, load and modulus buses.
- MOD_DEFAULT, 7, modulus loaded at reset; legal range 1..2^WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- clk_ena  in  1  global clock enable; when 0 all state holds.
- cnt_ena  in  1  count enable / cascade carry-in from the lower stage.
- srst  in  1  synchronous clear.
- load  in  1  synchronous load of dfload.
- dfload  in  WIDTH  load value.
- mod_load  in  1  update the modulus register from mod_val.
- mod_val  in  WIDTH  new modulus M.
- dir  in  1  0 = count up, 1 = count down.
- one_shot  in  1  1 = halt at terminal count, 0 = free-run.
- q  out  WIDTH  current count.
- mod_q  out  WIDTH  modulus in effect.
- carry  out  1  combinational cascade carry-out.
- tc_r  out  1  registered terminal-count pulse.
- done  out  1  one-shot halted flag.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low: rst_n=0 immediately forces q=0, mod_q=MOD_DEFAULT, tc_r=0, done=0.
  - All other updates occur on the rising edge of clk, and only when clk_ena=1. With clk_ena=0, q, mod_q, tc_r and done hold.
- Terminal condition (tc), computed on the current q and mod_q:
  - up: q==mod_q-1
  - down: q==0
- carry = clk_ena & cnt_ena & tc & ~done. Purely combinational, zero latency, for chaining into the next stage's cnt_ena.
- Priority per enabled edge (exclusive): srst > load > count.
  - srst: q<=0, done<=0.
  - load: q<=dfload, done<=0. If dfload>=mod_q (pre-edge), q<=mod_q-1 instead (clamp).
  - count, when cnt_ena=1 and done=0:
    - up: q<=(tc ? 0 : q+1)
    - down: q<=(tc ? mod_q-1 : q-1)
  - cnt_ena=0 or done=1: q holds.
- One-shot:
  - If one_shot=1 and a count edge occurs with tc=1, q holds at its terminal value (no wrap) and done<=1.
  - While done=1, cnt_ena is ignored and carry=0. Only srst, load or reset clear done.
  - Clearing one_shot while done=1 does not clear done.
- tc_r:
  - Each enabled edge, tc_r<=1 if that edge performed a terminal-count step (wrap, or halt in one-shot), else 0. One-cycle pulse, 1 clock after carry.
  - srst/load edges give tc_r<=0.
- Modulus register:
  - mod_load=1 with mod_val!=0: mod_q<=mod_val. mod_val==0 is ignored (mod_q holds).
  - The next-q value on that edge is computed with the old mod_q. If that next-q is >= the new mod_q, q<=0 instead.
- M=1: q stays 0. Every counted edge is terminal (carry each cycle with cnt_ena=1). In one-shot, the first counted edge sets done.
- Direction change takes effect at the edge where dir is sampled. No extra latency, no skipped state.
- Width: all arithmetic is modulo 2^WIDTH. q never leaves 0..mod_q-1, except transiently as described under the mod_load rule.

Test Plan:
- Reset / up wrap: rst_n pulse low mid-cycle, then cnt_ena=1, dir=0, default M=7.
  - Response: q is 0 asynchronously; then 0,1..6,0.
  - carry high only while q=6; tc_r high the cycle q returns to 0.
- Down, programmed modulus: mod_load with mod_val=5, dir=1.
  - Response: q 0,4,3,2,1,0,4.
  - carry while q=0; mod_q=5.
- Load, clamp and priority: M=7, load with dfload=3 → q=3.
  - dfload=9 → q=6.
  - srst and load together → q=0, tc_r=0.
- One-shot: one_shot=1, dir=0, M=4.
  - Response: q 0,1,2,3 then holds 3, done=1, tc_r one pulse.
  - Further cnt_ena has no effect, carry=0; load dfload=1 → q=1, done=0.
- Cascade: two instances, M=3 (low) and M=4 (high); low.carry drives high.cnt_ena.
  - Response: high increments once every 3 enabled cycles; combined sequence period 12.
  - Toggling clk_ena=0 for 5 cycles freezes both stages and forces carry=0.
- Modulus shrink: q=5 with M=8 counting up; mod_load mod_val=4 at that edge.
  - Response: next q=0 (6>=4), mod_q=4.
  - mod_val=0 → mod_q unchanged.
